// File: rtl/amba3_apb_arbiter_if.sv
// Bundles the requester-side command/response signals and the APB master
// port of the arbiter. The master modport is the arbiter's view; the slave
// modport is the view of whatever surrounds it (requesters plus APB fabric).
interface amba3_apb_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32
);
  // requester side
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ-1:0]           req_write;
  logic [NUM_REQ*ADDR_SIZE-1:0] req_addr;
  logic [NUM_REQ*DATA_SIZE-1:0] req_wdata;
  logic [NUM_REQ-1:0]           gnt;
  logic [NUM_REQ-1:0]           done;
  logic [DATA_SIZE-1:0]         rsp_rdata;
  logic                         rsp_err;
  logic                         busy;

  // APB side
  logic [ADDR_SIZE-1:0]         paddr;
  logic                         psel;
  logic                         penable;
  logic                         pwrite;
  logic [DATA_SIZE-1:0]         pwdata;
  logic                         pready;
  logic [DATA_SIZE-1:0]         prdata;

  modport master (
    input  req, req_write, req_addr, req_wdata, pready, prdata,
    output gnt, done, rsp_rdata, rsp_err, busy,
           paddr, psel, penable, pwrite, pwdata
  );

  modport slave (
    output req, req_write, req_addr, req_wdata, pready, prdata,
    input  gnt, done, rsp_rdata, rsp_err, busy,
           paddr, psel, penable, pwrite, pwdata
  );
endinterface

// File: rtl/amba3_apb_arbiter.sv
// Round-robin arbiter sharing one AMBA 3 APB master port among NUM_REQ
// requesters. One command per grant; returns read data or a timeout error.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  ST_IDLE   | bus idle, scanning req from ptr upward for the next winner
//  ST_SETUP  | APB setup phase (psel=1, penable=0), gnt pulse visible
//  ST_ACCESS | APB access phase, waiting on pready or the timeout counter
module amba3_apb_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32,
  parameter int TIMEOUT   = 256
) (
  input  logic                       pclk_i,
  input  logic                       preset_n_i,
  amba3_apb_arbiter_if.master        bus
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int SW = PW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // Down-counter load value: expires on the TIMEOUT-th ACCESS cycle.
  localparam logic [TW-1:0] TLOAD = (TIMEOUT > 1) ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [PW-1:0]          idx_q, idx_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;

  logic                   psel_q, psel_d;
  logic                   penable_q, penable_d;
  logic                   pwrite_q, pwrite_d;
  logic [ADDR_SIZE-1:0]   paddr_q, paddr_d;
  logic [DATA_SIZE-1:0]   pwdata_q, pwdata_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic [NUM_REQ-1:0]     done_q, done_d;
  logic [DATA_SIZE-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_err_q, rsp_err_d;
  logic                   busy_q, busy_d;

  logic [ADDR_SIZE-1:0]   addr_a  [NUM_REQ];
  logic [DATA_SIZE-1:0]   wdata_a [NUM_REQ];

  logic                   arb_hit;
  logic [PW-1:0]          arb_idx;
  logic                   xfer_end;
  logic                   xfer_err;
  logic [PW-1:0]          ptr_nxt;

  // Unpack the per-requester address/data buses.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g]  = bus.req_addr[g*ADDR_SIZE +: ADDR_SIZE];
    assign wdata_a[g] = bus.req_wdata[g*DATA_SIZE +: DATA_SIZE];
  end

  // Find the first pending request at or after ptr, wrapping around.
  always_comb begin : arb_scan
    logic [SW-1:0] slot;
    arb_hit = 1'b0;
    arb_idx = '0;
    slot    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      slot = {1'b0, ptr_q} + SW'(k);
      if (slot >= SW'(NUM_REQ)) begin
        slot = slot - SW'(NUM_REQ);
      end
      if (!arb_hit && bus.req[slot[PW-1:0]]) begin
        arb_hit = 1'b1;
        arb_idx = slot[PW-1:0];
      end
    end
  end

  assign ptr_nxt = (idx_q == PW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

  // Next-state and registered-output logic for the APB sequencer.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    tcnt_d      = tcnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    gnt_d       = '0;
    done_d      = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    busy_d      = busy_q;
    xfer_end    = 1'b0;
    xfer_err    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_hit) begin
          idx_d          = arb_idx;
          psel_d         = 1'b1;
          penable_d      = 1'b0;
          pwrite_d       = bus.req_write[arb_idx];
          paddr_d        = addr_a[arb_idx];
          pwdata_d       = bus.req_write[arb_idx] ? wdata_a[arb_idx] : '0;
          gnt_d[arb_idx] = 1'b1;
          busy_d         = 1'b1;
          state_d        = ST_SETUP;
        end
      end

      ST_SETUP: begin
        penable_d = 1'b1;
        tcnt_d    = TLOAD;
        state_d   = ST_ACCESS;
      end

      ST_ACCESS: begin
        // pready wins over a timeout expiring on the same edge.
        if (bus.pready) begin
          xfer_end = 1'b1;
        end else if ((TIMEOUT != 0) && (tcnt_q == '0)) begin
          xfer_end = 1'b1;
          xfer_err = 1'b1;
        end else if (TIMEOUT != 0) begin
          tcnt_d = tcnt_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (xfer_end) begin
      psel_d         = 1'b0;
      penable_d      = 1'b0;
      pwrite_d       = 1'b0;
      paddr_d        = '0;
      pwdata_d       = '0;
      done_d[idx_q]  = 1'b1;
      rsp_err_d      = xfer_err;
      rsp_rdata_d    = (xfer_err || pwrite_q) ? '0 : bus.prdata;
      busy_d         = 1'b0;
      ptr_d          = ptr_nxt;
      state_d        = ST_IDLE;
    end
  end

  // State and output registers; reset drops any transfer in flight.
  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      idx_q       <= '0;
      tcnt_q      <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      tcnt_q      <= tcnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/amba3_apb_arbiter.md
Name: amba3_apb_arbiter

Overview:
Shares one AMBA 3 APB master port among NUM_REQ internal requesters using round-robin arbitration. Each requester posts a single read or write command. The block sequences the APB SETUP/ACCESS phases, waits on pready, and returns the read data or a timeout error to the winning requester. It sits between the register-access clients (CPU bridge, DMA config, test sequencer) and the APB slave fabric.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
ADDR_SIZE, 32, APB address width
DATA_SIZE, 32, APB data width
TIMEOUT, 256, max ACCESS cycles waiting for pready; 0 disables the timeout

Ports:
pclk  input  1  APB clock; all logic on rising edge
preset_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-requester command valid; held until gnt
req_write  input  NUM_REQ  1 = write, 0 = read
req_addr  input  NUM_REQ*ADDR_SIZE  packed addresses; requester i at [i*ADDR_SIZE +: ADDR_SIZE]
req_wdata  input  NUM_REQ*DATA_SIZE  packed write data, same packing
gnt  output  NUM_REQ  one-hot, 1-cycle pulse; command latched
done  output  NUM_REQ  one-hot, 1-cycle pulse; transfer finished
rsp_rdata  output  DATA_SIZE  read data, valid while done is high
rsp_err  output  1  timeout flag, valid while done is high
busy  output  1  high from grant until done
paddr  output  ADDR_SIZE  APB address
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
pwdata  output  DATA_SIZE  APB write data
pready  input  1  APB slave ready
prdata  input  DATA_SIZE  APB read data

Behaviour:
- Reset (async, preset_n low):
  - All outputs go to 0 immediately: psel/penable/pwrite=0, paddr/pwdata=0, gnt/done=0, rsp_rdata=0, rsp_err=0, busy=0.
  - State = IDLE; round-robin pointer ptr = 0; timeout counter = 0.
- All outputs are registered. The idle bus drives paddr, pwdata, pwrite, psel and penable to 0.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any req bit is set, select the first set bit scanning from ptr upward with wrap.
  - Latch addr, wdata and write for the winner (i).
  - Next cycle: state = SETUP; psel=1, penable=0, paddr/pwrite set; pwdata = wdata on a write, 0 on a read; gnt[i]=1; busy=1.
  - req is ignored outside IDLE.
- SETUP: next cycle penable=1, state = ACCESS, gnt=0, timeout counter cleared.
- ACCESS, pready sampled high:
  - Next cycle: bus returns to idle values, done[i]=1, state = IDLE, busy=0, ptr = (i+1) mod NUM_REQ.
  - rsp_rdata = prdata on a read, 0 on a write; rsp_err=0.
- ACCESS, pready low:
  - Counter increments. When the counter reaches TIMEOUT-1 with pready still low, the next cycle aborts: bus idle, done[i]=1, rsp_err=1, rsp_rdata=0, ptr advances as above.
  - TIMEOUT=0 means wait forever.
- Latency, zero-wait slave, req sampled at edge E0:
  - gnt and psel appear after E0.
  - penable appears after E1.
  - pready is sampled at E2; done appears after E2.
  - The next arbitration is at E3, so there is always one idle bus cycle between transfers.
- Simultaneous events:
  - A requester may raise req in its done cycle and competes at the next IDLE edge.
  - pready and the timeout expiring on the same edge counts as success (rsp_err=0).
- A requester that drops req before gnt is not served, and no state changes.
- A reset mid-transfer drops the transfer silently (no done). Requesters must reissue.
- The ptr update is the only fairness state. A requester holding req continuously is served at most once per NUM_REQ grants while others are pending.

Test Plan:
- Single write: req[0], addr 0x10, wdata 0xA5A5_0001, slave pready=1 -> psel at E1, penable at E2, pwdata=0xA5A5_0001 while psel=1, done[0] after E2 with rsp_err=0, then psel=0 and all bus signals 0.
- Read with 3 wait states: req[2] read addr 0x40, pready low for 3 ACCESS cycles then high with prdata=0xDEAD_BEEF -> done[2] with rsp_rdata=0xDEAD_BEEF, penable high for 4 cycles.
- Round robin: req=4'b1111 held, re-raised after each gnt -> grant order 0,1,2,3,0, with exactly one psel=0 cycle between transfers.
- Timeout: TIMEOUT=8, pready stuck low -> done pulse after 8 ACCESS cycles with rsp_err=1 and rsp_rdata=0; ptr advances; the next request completes normally.
- Reset mid-ACCESS: assert preset_n low while penable=1 -> psel/penable drop asynchronously with no done pulse; after release, ptr=0 and req[1] is served first.
- Boundary: pready goes high on the exact TIMEOUT-1 cycle -> success with rsp_err=0; a req pulse dropped before gnt is never granted.
